// File: rtl/flt2int_seq.sv
// flt2int_seq: sequential half-precision float to int16 converter.
// Reads the operand bytes from data_mem and writes the rounded, saturated result back.
module flt2int_seq #(
   parameter logic [7:0] IN_ADDR  = 8'd4,
   parameter logic [7:0] OUT_ADDR = 8'd6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic [7:0] DataAddress,
   output logic       ReadMem,
   output logic       WriteMem,
   output logic [7:0] DataIn,
   input  logic [7:0] DataOut
);

   typedef enum logic [3:0] {
      IDLE, RD_LO, RD_HI, DECODE, SHIFT, ROUND, WR_LO, WR_HI, DONE
   } state_t;

   state_t state, state_nx;

   logic [7:0]  lo, hi;
   logic [16:0] mag;
   logic        guard, sticky, left;
   logic [4:0]  cnt;
   logic [15:0] res;

   logic        sgn;
   logic [4:0]  e;
   logic [4:0]  amt;
   logic [16:0] mag_r;
   logic [15:0] rounded;

   assign sgn = hi[7];
   assign e   = hi[6:2];
   assign amt = (e >= 5'd25) ? (e - 5'd25) : (5'd25 - e);

   // Round to nearest even; left shifts leave guard/sticky clear.
   assign mag_r = mag + {16'd0, guard & (sticky | mag[0])};

   always_comb begin
      rounded = mag_r[15:0];
      if (!sgn) begin
         if (mag_r > 17'd32767) rounded = 16'h7FFF;
      end else begin
         if (mag_r > 17'd32768) rounded = 16'h8000;
         else                   rounded = 16'd0 - mag_r[15:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      done        = 1'b0;
      DataAddress = 8'd0;
      ReadMem     = 1'b0;
      WriteMem    = 1'b0;
      DataIn      = 8'd0;
      unique case (state)
         IDLE: if (start) state_nx = RD_LO;
         RD_LO: begin
            DataAddress = IN_ADDR;
            ReadMem     = 1'b1;
            state_nx    = RD_HI;
         end
         RD_HI: begin
            DataAddress = IN_ADDR + 8'd1;
            ReadMem     = 1'b1;
            state_nx    = DECODE;
         end
         DECODE: begin
            if (e == 5'd31 || e <= 5'd13) state_nx = WR_LO;
            else if (amt == 5'd0)         state_nx = ROUND;
            else                          state_nx = SHIFT;
         end
         SHIFT: if (cnt == 5'd1) state_nx = ROUND;
         ROUND: state_nx = WR_LO;
         WR_LO: begin
            DataAddress = OUT_ADDR;
            WriteMem    = 1'b1;
            DataIn      = res[7:0];
            state_nx    = WR_HI;
         end
         WR_HI: begin
            DataAddress = OUT_ADDR + 8'd1;
            WriteMem    = 1'b1;
            DataIn      = res[15:8];
            state_nx    = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = RD_LO;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lo     <= 8'd0;
         hi     <= 8'd0;
         mag    <= 17'd0;
         guard  <= 1'b0;
         sticky <= 1'b0;
         left   <= 1'b0;
         cnt    <= 5'd0;
         res    <= 16'd0;
      end else begin
         case (state)
            RD_LO: lo <= DataOut;
            RD_HI: hi <= DataOut;
            DECODE: begin
               guard  <= 1'b0;
               sticky <= 1'b0;
               mag    <= {6'd0, 1'b1, hi[1:0], lo};
               left   <= (e >= 5'd25);
               cnt    <= amt;
               if (e == 5'd31)      res <= sgn ? 16'h8000 : 16'h7FFF;
               else if (e <= 5'd13) res <= 16'd0;
            end
            SHIFT: begin
               cnt <= cnt - 5'd1;
               if (left) begin
                  mag <= mag << 1;
               end else begin
                  mag    <= mag >> 1;
                  guard  <= mag[0];
                  sticky <= sticky | guard;
               end
            end
            ROUND: res <= rounded;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/flt2int_seq.md
FLT2INT_SEQ -- requirements
Module: flt2int_seq

Interface
REQ-001 SHALL have parameter IN_ADDR, default 8'd4, byte address of the input float's LSB; its MSB is at IN_ADDR+1.
REQ-002 SHALL have parameter OUT_ADDR, default 8'd6, byte address of the result LSB; its MSB is at OUT_ADDR+1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, request to begin one conversion.
REQ-006 SHALL have port done, output, 1 bit, conversion complete and result written.
REQ-007 SHALL have port DataAddress, output, 8 bits, data_mem address.
REQ-008 SHALL have port ReadMem, output, 1 bit, read strobe.
REQ-009 SHALL have port WriteMem, output, 1 bit, write enable; data_mem writes on the rising clk edge.
REQ-010 SHALL have port DataIn, output, 8 bits, write data to data_mem.
REQ-011 SHALL have port DataOut, input, 8 bits, combinational read data from data_mem[DataAddress].

Function
REQ-012 SHALL convert an IEEE half-precision float (sign [15], exponent [14:10] bias 15, mantissa [9:0]) to a 16-bit two's-complement integer.
REQ-013 SHALL use FSM states IDLE, RD_LO, RD_HI, DECODE, SHIFT, ROUND, WR_LO, WR_HI and DONE.
REQ-014 SHALL accept start only in IDLE or DONE: the next state is RD_LO and done drops to 0 on that edge; start in any other state is ignored.
REQ-015 SHALL, in RD_LO, drive DataAddress=IN_ADDR with ReadMem=1 and capture DataOut at the edge; RD_HI does the same for IN_ADDR+1 (MSB).
REQ-016 SHALL, in DECODE, form significand sig={1,mant} (11 bits) and classify on exponent e:
  - e=31 (inf/NaN): saturate by sign and go to WR_LO.
  - e<=13: result 0 and go to WR_LO.
  - e=0 (zero/subnormal): result 0.
  - otherwise go to SHIFT.
REQ-017 SHALL, in SHIFT, move the magnitude register (17 bits) one bit per cycle:
  - e>=25: left by e-25 positions, 0-5 cycles.
  - e<25: right by 25-e positions, 1-11 cycles.
  - Right shifts keep a guard bit (last bit shifted out) and a sticky bit (OR of all earlier bits shifted out).
REQ-018 SHALL, in ROUND, apply round-to-nearest-even on the magnitude: increment if guard and (sticky or LSB); the carry is kept in bit 16.
REQ-019 SHALL saturate after rounding:
  - Positive with magnitude > 32767 gives 16'h7FFF.
  - Negative with magnitude > 32768 gives 16'h8000.
  - Otherwise the result is magnitude, or its two's complement when sign=1.
REQ-020 SHALL yield 16'h0000, never 16'hFFFF or -0, when a negative input rounds to magnitude 0.
REQ-021 SHALL, in WR_LO, drive DataAddress=OUT_ADDR, WriteMem=1, DataIn=result[7:0]; in WR_HI, OUT_ADDR+1 with result[15:8].
REQ-022 SHALL enter DONE after WR_HI, assert done=1 there, and hold done until the next accepted start.
REQ-023 SHALL hold ReadMem=0 and WriteMem=0 in all states except those in REQ-015 and REQ-021.
REQ-024 SHALL reach done=1 no later than 18 clk cycles after the accepting edge, for any input.
REQ-025 SHALL decide saturation on sign alone for NaN; the NaN payload is ignored.
REQ-026 SHALL write exactly two bytes per conversion and never touch any address other than IN_ADDR..IN_ADDR+1 and OUT_ADDR..OUT_ADDR+1.

Reset
REQ-027 SHALL, while reset=0, immediately force state IDLE, done=0, ReadMem=0, WriteMem=0, DataAddress=0, DataIn=0, and clear all datapath registers.
REQ-028 SHALL abort a conversion in progress when reset asserts: no further memory writes occur and previously written bytes are not restored.
REQ-029 SHALL require a fresh start after reset deasserts; a start held high through reset release is accepted at the first rising edge with reset=1.

Verification
REQ-030 SHALL pass exact values: 0x3C00 -> 0x0001; 0xC500 (-5.0) -> 0xFFFB; 0x77FF (32752) -> 0x7FF0; 0x0000 -> 0x0000; 0x8001 -> 0x0000.
REQ-031 SHALL pass rounding ties and sign: 0x3E00 (1.5) -> 0x0002; 0x4100 (2.5) -> 0x0002; 0x3800 (0.5) -> 0x0000; 0x3A00 (0.75) -> 0x0001; 0xBA00 (-0.75) -> 0xFFFF.
REQ-032 SHALL pass saturation: 0x7BFF (65504) -> 0x7FFF; 0xF800 (-32768) -> 0x8000; 0x7C00 (+inf) -> 0x7FFF; 0xFE00 (NaN, sign 1) -> 0x8000.
REQ-033 SHALL pass handshake and latency: start pulsed during SHIFT is ignored with no extra writes; done rises within 18 cycles; back-to-back start in DONE works.
REQ-034 SHALL pass reset mid-operation: reset=0 asserted during SHIFT for input 0x4100 -> done=0 and WriteMem=0 at once, and mem[OUT_ADDR..+1] unchanged.
